// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   rsz_e   : read size codes driven onto the memory's MemRead input
//   wsz_e   : write size codes driven onto the memory's MemWrite input
//   CORE    : port index of the pipeline MEM stage
//   LDR     : port index of the loader/debug port
// Configuration macro: DMEM_ARB_CORE_PRIO_EN (consumed by rr_arbiter_2).
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        RD_W    = 3'b000,
        RD_H    = 3'b001,
        RD_HU   = 3'b010,
        RD_B    = 3'b011,
        RD_BU   = 3'b100,
        RD_NONE = 3'b111
    } rsz_e;

    typedef enum logic [1:0] {
        WR_W    = 2'b00,
        WR_H    = 2'b01,
        WR_B    = 2'b10,
        WR_NONE = 2'b11
    } wsz_e;

    localparam int CORE = 0;
    localparam int LDR  = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-way combinational arbiter for the data-memory port.
//   req[1:0]  in   requests, bit CORE = MEM stage, bit LDR = loader
//   last_gnt  in   index of the port granted most recently
//   gnt[1:0]  out  one-hot grant (or zero when nobody asks)
// Configuration macro: DMEM_ARB_CORE_PRIO_EN
//   defined   : fixed priority, the core port always wins contention
//   undefined : round-robin, contention goes to the port that did not win last
module rr_arbiter_2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_CORE_PRIO_EN
    // The history bit is still tracked by the parent but has no say here.
    logic prio_unused_last;
    assign prio_unused_last = last_gnt;
`endif

    // A lone requester always wins; only the both-requesting case needs a
    // policy decision.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt[CORE] = 1'b1;
            2'b10: gnt[LDR]  = 1'b1;
            2'b11: begin
`ifdef DMEM_ARB_CORE_PRIO_EN
                gnt[CORE] = 1'b1;
`else
                if (last_gnt) gnt[CORE] = 1'b1;
                else          gnt[LDR]  = 1'b1;
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (port 0)
// and the loader/debug port (port 1). One access per cycle is steered onto
// the memory; read data is registered back to the winning port.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   p_req/p_we           per-port request and write-enable
//   p_rsz/p_wsz          per-port read / write size codes
//   p_addr/p_wdata       per-port word address and write data
//   p_gnt                combinational grant
//   p_rvalid/p_rdata     read response (pulse one cycle after a granted read)
//   core_stall           MEM stage is requesting but not granted
//   m_addr/m_wd          memory address / write data
//   m_read/m_write       memory MemRead / MemWrite codes (idle = 3'b111 / 2'b11)
//   m_rd                 memory read data (combinational)
//   wait_cnt             per-port saturating count of unserved request cycles
//   err_sticky           a write with size code 2'b11 was granted
// Configuration macro: DMEM_ARB_CORE_PRIO_EN (fixed priority to port 0).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   p_req,
    input  logic [1:0]                   p_we,
    input  logic [1:0][2:0]              p_rsz,
    input  logic [1:0][1:0]              p_wsz,
    input  logic [1:0][DM_ADDRESS-1:0]   p_addr,
    input  logic [1:0][DATA_W-1:0]       p_wdata,
    output logic [1:0]                   p_gnt,
    output logic [1:0]                   p_rvalid,
    output logic [1:0][DATA_W-1:0]       p_rdata,
    output logic                         core_stall,
    output logic [DM_ADDRESS-1:0]        m_addr,
    output logic [DATA_W-1:0]            m_wd,
    output logic [2:0]                   m_read,
    output logic [1:0]                   m_write,
    input  logic [DATA_W-1:0]            m_rd,
    output logic [1:0][CNT_W-1:0]        wait_cnt,
    output logic                         err_sticky
);

    logic [1:0] arb_gnt;
    logic       last_gnt;
    logic       granted;
    logic       sel;
    logic [1:0] rvalid_q;

    rr_arbiter_2 u_arb (
        .req      (p_req),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt)
    );

    // Reset is synchronous, so the reset cycle itself must look idle to the
    // memory: grants are masked combinationally while reset is high.
    assign p_gnt   = arb_gnt & {2{~reset}};
    assign granted = |p_gnt;
    assign sel     = p_gnt[LDR];

    assign core_stall = p_req[CORE] & ~p_gnt[CORE];

    // A response pulse whose cycle coincides with reset is dropped.
    assign p_rvalid = rvalid_q & {2{~reset}};

    // Steer the winner's payload onto the memory; the unused direction is
    // parked on its "none" code so a read never writes and vice versa.
    always_comb begin
        m_addr  = '0;
        m_wd    = '0;
        m_read  = RD_NONE;
        m_write = WR_NONE;
        if (granted) begin
            m_addr = p_addr[sel];
            m_wd   = p_wdata[sel];
            if (p_we[sel]) m_write = p_wsz[sel];
            else           m_read  = p_rsz[sel];
        end
    end

    // Arbitration history: remembers the last winner, holds through idle cycles.
    always_ff @(posedge clk) begin
        if (reset)        last_gnt <= 1'b1;
        else if (granted) last_gnt <= sel;
    end

    // Read response: capture memory data on the grant edge, pulse valid the
    // following cycle. p_rdata holds until that port's next read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= '0;
            p_rdata  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= p_gnt[i] & ~p_we[i];
                if (p_gnt[i] & ~p_we[i]) p_rdata[i] <= m_rd;
            end
        end
    end

    // Starvation counters: one tick per cycle spent requesting without a
    // grant, pinned at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (p_req[i] & ~p_gnt[i] & ~&wait_cnt[i])
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
            end
        end
    end

    // A granted write with the "none" size code is accepted but flagged.
    always_ff @(posedge clk) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (granted & p_we[sel] & (p_wsz[sel] == WR_NONE))
            err_sticky <= 1'b1;
    end

endmodule
